// File: rtl/audio_source_switch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_source_switch_if                                                   |
// | Bundle of source inputs, mixed output and status for audio_source_switch |
// | Optional peak meter signals appear with AUDIO_SWITCH_PEAK_EN             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface audio_source_switch_if #(
    parameter int NUM_SRC = 4,
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 24
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic                               run;
    logic [SEL_W-1:0]                   select;
    logic [NUM_SRC-1:0]                 src_valid;
    logic [NUM_SRC*NUM_CH*DATA_W-1:0]   src_data;
    logic                               dout_valid;
    logic [NUM_CH*DATA_W-1:0]           dout_data;
    logic [SEL_W-1:0]                   active_sel;
    logic                               switching;
    logic                               timeout_flag;
`ifdef AUDIO_SWITCH_PEAK_EN
    logic                               peak_clr;
    logic [NUM_CH*DATA_W-1:0]           peak_level;

    modport master (
        output run, select, src_valid, src_data, peak_clr,
        input  dout_valid, dout_data, active_sel, switching, timeout_flag, peak_level
    );
    modport slave (
        input  run, select, src_valid, src_data, peak_clr,
        output dout_valid, dout_data, active_sel, switching, timeout_flag, peak_level
    );
`else
    modport master (
        output run, select, src_valid, src_data,
        input  dout_valid, dout_data, active_sel, switching, timeout_flag
    );
    modport slave (
        input  run, select, src_valid, src_data,
        output dout_valid, dout_data, active_sel, switching, timeout_flag
    );
`endif
endinterface
`default_nettype wire

// File: rtl/audio_source_switch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_source_switch                                                      |
// | N-source PCM selector with click-free linear fade swap and stall timeout |
// | Optional per-channel peak meter: AUDIO_SWITCH_PEAK_EN                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module audio_source_switch #(
    parameter int NUM_SRC    = 4,
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 24,
    parameter int RAMP_SHIFT = 6,
    parameter int TIMEOUT    = 4096
) (
    input  wire logic           clk,
    input  wire logic           reset,
    audio_source_switch_if.slave bus
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int G_W   = RAMP_SHIFT + 1;
    localparam int P_W   = DATA_W + RAMP_SHIFT + 2;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [G_W-1:0]   c_g_full  = G_W'(1 << RAMP_SHIFT);
    localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        FADE_OUT = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [G_W-1:0]            g_q, g_d;
    logic [SEL_W-1:0]          pending_q, pending_d;
    logic [SEL_W-1:0]          req_q, req_d;
    logic [SEL_W-1:0]          active_sel_q, active_sel_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      dout_valid_q, dout_valid_d;
    logic [NUM_CH*DATA_W-1:0]  dout_data_q, dout_data_d;
    logic                      switching_q, switching_d;
    logic                      timeout_flag_q, timeout_flag_d;

    logic                      w_sel_ok;
    logic [SEL_W-1:0]          w_req;
    logic                      w_act_v;
    logic [G_W-1:0]            w_g_dec;
    logic [G_W-1:0]            w_g_inc;
    logic [NUM_CH*DATA_W-1:0]  w_scaled;

    // Scale each channel of the routed source by the current gain
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [DATA_W-1:0] w_smp;
        logic signed [P_W-1:0]    w_prod;
        logic signed [P_W-1:0]    w_shf;
        assign w_smp  = bus.src_data[(int'(active_sel_q) * NUM_CH + c) * DATA_W +: DATA_W];
        assign w_prod = P_W'(w_smp) * $signed(P_W'({1'b0, g_q}));
        assign w_shf  = w_prod >>> RAMP_SHIFT;
        assign w_scaled[c*DATA_W +: DATA_W] = w_shf[DATA_W-1:0];
    end

    assign w_sel_ok = int'(bus.select) < NUM_SRC;
    assign w_req    = w_sel_ok ? bus.select : req_q;
    assign w_act_v  = (state_q != IDLE) && bus.src_valid[active_sel_q];
    assign w_g_dec  = (g_q == '0) ? g_q : g_q - 1'b1;
    assign w_g_inc  = (g_q == c_g_full) ? g_q : g_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        g_d            = g_q;
        pending_d      = pending_q;
        req_d          = w_req;
        active_sel_d   = active_sel_q;
        cnt_d          = '0;
        dout_valid_d   = 1'b0;
        dout_data_d    = dout_data_q;
        timeout_flag_d = timeout_flag_q;
        if (!bus.run) begin
            state_d        = IDLE;
            g_d            = c_g_full;
            pending_d      = '0;
            active_sel_d   = '0;
            dout_data_d    = '0;
            timeout_flag_d = 1'b0;
        end else begin
            if (w_act_v) begin
                dout_valid_d = 1'b1;
                dout_data_d  = w_scaled;
            end
            case (state_q)
                IDLE: begin
                    active_sel_d = w_req;
                    g_d          = c_g_full;
                    state_d      = PLAY;
                end
                PLAY: begin
                    if (w_req != active_sel_q) begin
                        pending_d = w_req;
                        state_d   = FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    pending_d = w_req;
                    if (w_act_v) g_d = w_g_dec;
                    if (w_req == active_sel_q) begin
                        state_d = FADE_IN;
                    end else if (w_act_v && (w_g_dec == '0)) begin
                        active_sel_d = pending_q;
                        state_d      = FADE_IN;
                    end else if (!w_act_v && (cnt_q == c_to_last)) begin
                        // Fading source has stalled: swap without waiting for the ramp
                        g_d            = '0;
                        active_sel_d   = pending_q;
                        timeout_flag_d = 1'b1;
                        state_d        = FADE_IN;
                    end else if (!w_act_v) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FADE_IN: begin
                    if (w_act_v) g_d = w_g_inc;
                    if (w_req != active_sel_q) begin
                        pending_d = w_req;
                        state_d   = FADE_OUT;
                    end else if (w_act_v && (w_g_inc == c_g_full)) begin
                        state_d = PLAY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        switching_d = (state_d == FADE_OUT) || (state_d == FADE_IN);
    end

`ifdef AUDIO_SWITCH_PEAK_EN
    logic [NUM_CH*DATA_W-1:0] peak_q, peak_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_peak
        logic signed [DATA_W-1:0] w_v;
        logic [DATA_W-1:0]        w_mag;
        logic [DATA_W-1:0]        w_base;
        assign w_v    = dout_data_d[c*DATA_W +: DATA_W];
        assign w_mag  = (w_v == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}} :
                        w_v[DATA_W-1] ? DATA_W'(-w_v) : DATA_W'(w_v);
        assign w_base = bus.peak_clr ? '0 : peak_q[c*DATA_W +: DATA_W];
        assign peak_d[c*DATA_W +: DATA_W] = (dout_valid_d && (w_mag > w_base)) ? w_mag : w_base;
    end

    assign bus.peak_level = peak_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            g_q            <= c_g_full;
            pending_q      <= '0;
            req_q          <= '0;
            active_sel_q   <= '0;
            cnt_q          <= '0;
            dout_valid_q   <= 1'b0;
            dout_data_q    <= '0;
            switching_q    <= 1'b0;
            timeout_flag_q <= 1'b0;
`ifdef AUDIO_SWITCH_PEAK_EN
            peak_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            g_q            <= g_d;
            pending_q      <= pending_d;
            req_q          <= req_d;
            active_sel_q   <= active_sel_d;
            cnt_q          <= cnt_d;
            dout_valid_q   <= dout_valid_d;
            dout_data_q    <= dout_data_d;
            switching_q    <= switching_d;
            timeout_flag_q <= timeout_flag_d;
`ifdef AUDIO_SWITCH_PEAK_EN
            peak_q         <= peak_d;
`endif
        end
    end

    assign bus.dout_valid   = dout_valid_q;
    assign bus.dout_data    = dout_data_q;
    assign bus.active_sel   = active_sel_q;
    assign bus.switching    = switching_q;
    assign bus.timeout_flag = timeout_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_source_switch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_audio_source_switch                                                   |
// | Scoreboard bench: start-up, fades, reversal, timeout, run drop           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_audio_source_switch;
    localparam int NUM_SRC    = 3;
    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 24;
    localparam int RAMP_SHIFT = 2;
    localparam int TIMEOUT    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    audio_source_switch_if #(.NUM_SRC(NUM_SRC), .NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    audio_source_switch #(
        .NUM_SRC(NUM_SRC), .NUM_CH(NUM_CH), .DATA_W(DATA_W),
        .RAMP_SHIFT(RAMP_SHIFT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [NUM_CH*DATA_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (!reset && bus.dout_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_dout", 64'(bus.dout_valid), 64'd0);
            else                   chk("dout", 64'(bus.dout_data), 64'(exp_q.pop_front()));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                        input bit expect_out, input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1);
        bus.src_data = '0;
        bus.src_data[(s*NUM_CH+0)*DATA_W +: DATA_W] = d0;
        bus.src_data[(s*NUM_CH+1)*DATA_W +: DATA_W] = d1;
        bus.src_valid    = '0;
        bus.src_valid[s] = 1'b1;
        if (expect_out) exp_q.push_back({e1, e0});
        @(posedge clk);
        #1 bus.src_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input int sel, input bit sw);
        chk({tag, "_active_sel"}, 64'(bus.active_sel), 64'(sel));
        chk({tag, "_switching"},  64'(bus.switching),  64'(sw));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.run       = 1'b0;
        bus.select    = '0;
        bus.src_valid = '0;
        bus.src_data  = '0;
`ifdef AUDIO_SWITCH_PEAK_EN
        bus.peak_clr  = 1'b0;
`endif
        wait_cyc(3);
        chk("rst_dout_valid",   64'(bus.dout_valid),   64'd0);
        chk("rst_dout_data",    64'(bus.dout_data),    64'd0);
        chk("rst_timeout_flag", 64'(bus.timeout_flag), 64'd0);
        chk_status("rst", 0, 1'b0);
        reset = 1'b0;
        wait_cyc(1);

        // Startup straight into PLAY on source 2, bit-exact
        bus.run = 1'b1; bus.select = 2'd2;
        wait_cyc(1);
        chk_status("start", 2, 1'b0);
        send(2, 24'h123456, 24'hEDCBA9, 1, 24'h123456, 24'hEDCBA9);
        send(2, 24'hEDCBA9, 24'h123456, 1, 24'hEDCBA9, 24'h123456);
        send(1, 24'h111111, 24'h222222, 0, 24'h0, 24'h0);

        // Fade 2 -> 0, positive and negative channels
        bus.select = 2'd0;
        wait_cyc(1);
        chk_status("fo20", 2, 1'b1);
        send(2, 24'h100000, 24'hF00000, 1, 24'h100000, 24'hF00000);
        send(2, 24'h100000, 24'hF00000, 1, 24'h0C0000, 24'hF40000);
        send(2, 24'h100000, 24'hF00000, 1, 24'h080000, 24'hF80000);
        send(2, 24'h100000, 24'hF00000, 1, 24'h040000, 24'hFC0000);
        chk_status("swap20", 0, 1'b1);
        send(0, 24'h100000, 24'hF00000, 1, 24'h000000, 24'h000000);
        send(0, 24'h100000, 24'hF00000, 1, 24'h040000, 24'hFC0000);
        send(0, 24'h100000, 24'hF00000, 1, 24'h080000, 24'hF80000);
        send(0, 24'h100000, 24'hF00000, 1, 24'h0C0000, 24'hF40000);
        chk_status("play0", 0, 1'b0);
        send(0, 24'h100000, 24'hF00000, 1, 24'h100000, 24'hF00000);
        send(0, 24'h000001, 24'hFFFFFF, 1, 24'h000001, 24'hFFFFFF);

        // Out-of-range request is ignored
        bus.select = 2'd3;
        wait_cyc(2);
        chk_status("oor", 0, 1'b0);
        send(0, 24'h654321, 24'h9ABCDE, 1, 24'h654321, 24'h9ABCDE);

        // Fade 0 -> 1; -1 floors to -1 under arithmetic shift
        bus.select = 2'd1;
        wait_cyc(1);
        send(0, 24'h100000, 24'hFFFFFF, 1, 24'h100000, 24'hFFFFFF);
        send(0, 24'h100000, 24'hFFFFFF, 1, 24'h0C0000, 24'hFFFFFF);
        send(0, 24'h100000, 24'hFFFFFF, 1, 24'h080000, 24'hFFFFFF);
        send(0, 24'h100000, 24'hFFFFFF, 1, 24'h040000, 24'hFFFFFF);
        chk_status("swap01", 1, 1'b1);
        send(1, 24'h100000, 24'hF00000, 1, 24'h000000, 24'h000000);
        send(1, 24'h100000, 24'hF00000, 1, 24'h040000, 24'hFC0000);
        send(1, 24'h100000, 24'hF00000, 1, 24'h080000, 24'hF80000);
        send(1, 24'h100000, 24'hF00000, 1, 24'h0C0000, 24'hF40000);
        chk_status("play1", 1, 1'b0);

        // Reversal after two fade-out samples: resume from g=2 on the same source
        bus.select = 2'd0;
        wait_cyc(1);
        send(1, 24'h100000, 24'h100000, 1, 24'h100000, 24'h100000);
        send(1, 24'h100000, 24'h100000, 1, 24'h0C0000, 24'h0C0000);
        bus.select = 2'd1;
        wait_cyc(1);
        chk_status("rev", 1, 1'b1);
        send(1, 24'h100000, 24'h100000, 1, 24'h080000, 24'h080000);
        send(1, 24'h100000, 24'h100000, 1, 24'h0C0000, 24'h0C0000);
        chk_status("rev_play", 1, 1'b0);
        send(1, 24'h100000, 24'h100000, 1, 24'h100000, 24'h100000);

        // Dead source: forced swap TIMEOUT cycles after the last valid
        bus.select = 2'd2;
        wait_cyc(1);
        send(1, 24'h100000, 24'h100000, 1, 24'h100000, 24'h100000);
        n = 0;
        while (n < 40 && bus.active_sel != 2'd2) begin
            wait_cyc(1);
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'(TIMEOUT - 1));
        chk("timeout_flag", 64'(bus.timeout_flag), 64'd1);
        chk_status("to", 2, 1'b1);
        send(2, 24'h100000, 24'h100000, 1, 24'h000000, 24'h000000);
        send(2, 24'h100000, 24'h100000, 1, 24'h040000, 24'h040000);
        send(2, 24'h100000, 24'h100000, 1, 24'h080000, 24'h080000);
        send(2, 24'h100000, 24'h100000, 1, 24'h0C0000, 24'h0C0000);
        chk_status("to_play", 2, 1'b0);
        chk("timeout_sticky", 64'(bus.timeout_flag), 64'd1);

        // run dropped mid-fade, then restart straight into PLAY
        bus.select = 2'd0;
        wait_cyc(1);
        send(2, 24'h100000, 24'h100000, 1, 24'h100000, 24'h100000);
        bus.run = 1'b0;
        wait_cyc(1);
        chk("idle_dout_valid", 64'(bus.dout_valid), 64'd0);
        chk("idle_switching",  64'(bus.switching),  64'd0);
        chk("idle_timeout",    64'(bus.timeout_flag), 64'd0);
        send(2, 24'h100000, 24'h100000, 0, 24'h0, 24'h0);
        bus.run = 1'b1;
        wait_cyc(1);
        chk_status("restart", 0, 1'b0);
        send(0, 24'h123456, 24'hF00000, 1, 24'h123456, 24'hF00000);

        wait_cyc(3);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/audio_source_switch.md
Name: audio_source_switch

Overview:
- Parametrised N-source, C-channel PCM source selector: the successor to the fixed 4-input, 2-channel output mux that sits between the processing chain and PCM_to_I2S_Converter.
- Changes source without clicks. On a select change it fades the current source out with a linear gain ramp, swaps to the new source, then fades it in.
- Recovers from a stalled source with a timeout.
- Exposes the active source and switching status for the CPU audio_status register.

Parameters:
- NUM_SRC, 4, number of input sources (>=2)
- NUM_CH, 2, channels per source; all channels of one source share one valid strobe
- DATA_W, 24, signed sample width
- RAMP_SHIFT, 6, ramp length is 2^RAMP_SHIFT samples; gain g has RAMP_SHIFT+1 bits, full scale G_FULL = 2^RAMP_SHIFT
- TIMEOUT, 4096, clk cycles without a valid from the fading source before a forced swap
- SEL_W, max(1, $clog2(NUM_SRC)), derived select width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  block enable (audio_control[0])
- select  in  SEL_W  requested source index
- src_valid  in  NUM_SRC  per-source sample strobe, 1 cycle
- src_data  in  NUM_SRC*NUM_CH*DATA_W  source s, channel c at bits [(s*NUM_CH+c)*DATA_W +: DATA_W]
- dout_valid  out  1  output strobe
- dout_data  out  NUM_CH*DATA_W  scaled samples, same channel packing
- active_sel  out  SEL_W  source currently routed
- switching  out  1  high in FADE_OUT or FADE_IN
- timeout_flag  out  1  sticky; set on forced swap, cleared by reset or run=0

Behaviour:
- Decided: one clock, clk; reset synchronous active-high; all state is registered on the rising edge of clk.
- Reset values:
  - dout_valid=0, dout_data=0, active_sel=0, switching=0, timeout_flag=0
  - state=IDLE, g=G_FULL, pending=0, timeout counter=0
- States: IDLE, PLAY, FADE_OUT, FADE_IN.
- IDLE:
  - Outputs are held at 0.
  - On run=1: active_sel<=select, g<=G_FULL, go to PLAY (no fade on start).
- run=0 in any state: next cycle go to IDLE, dout_valid=0, g=G_FULL. Any fade in progress is abandoned.
- Out-of-range select (>=NUM_SRC) is ignored; the previous request stays in force.
- Datapath:
  - Triggered when src_valid[active_sel]=1 in a non-IDLE state.
  - Next cycle: dout_valid=1 and each channel = (sample * g) >>> RAMP_SHIFT, with signed full-precision product and arithmetic shift.
  - Latency is exactly 1 clk. dout_data holds its value between strobes.
  - When g=G_FULL the output is bit-exact to the input.
  - The sample is scaled with the pre-update g; g then updates on the same edge.
  - Valids from non-active sources are ignored.
- PLAY:
  - If select != active_sel (and is valid): pending<=select, go to FADE_OUT.
- FADE_OUT:
  - Each active valid decrements g by 1.
  - pending tracks select every cycle.
  - If select returns to active_sel: go to FADE_IN from the current g (reversal, no swap).
  - When g reaches 0 after a decrement: active_sel<=pending, go to FADE_IN.
- FADE_IN:
  - Each active valid increments g by 1.
  - When g reaches G_FULL: go to PLAY.
  - If select != active_sel: pending<=select, go to FADE_OUT from the current g.
- Timeout:
  - The counter clears on every active valid and counts while in FADE_OUT.
  - At TIMEOUT: force g=0, active_sel<=pending, set timeout_flag, go to FADE_IN.
- Simultaneous select change and active valid: the sample is processed with the current g, and the state transition takes effect on the same edge.
- g is saturated to 0..G_FULL; it never wraps.

Optional Feature:
- Macro: AUDIO_SWITCH_PEAK_EN.
- Defined:
  - Adds output peak_level [NUM_CH*DATA_W] (reset 0) holding the per-channel maximum |dout| since the last clear.
  - Adds input peak_clr (1 cycle), which zeroes all peaks. If peak_clr coincides with a new sample, the new sample's |value| is loaded.
  - |most-negative| saturates to max positive.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Startup: reset, run=1, select=2, src2 strobes 0x123456 / 0xEDCBA9 -> active_sel=2, dout equals the input 1 clk after each valid, switching=0.
- Fade swap (RAMP_SHIFT=2): in PLAY on src0 with constant 0x100000, set select=1 -> the next 4 src0 outputs are 0x100000, 0x0C0000, 0x080000, 0x040000; active_sel=1. Then src1 outputs at g=0,1,2,3 (0x000000, 0x040000, ... for 0x100000 input), then PLAY.
- Negative scaling: -0x100000 (0xF00000) at g=3 of 4 -> 0xF40000.
- Reversal: select 0->1, after 2 fade-out samples select back to 0 -> FADE_IN from g=2, no swap, active_sel stays 0.
- Dead source: in FADE_OUT stop src0 valids, TIMEOUT=16 -> after 16 cycles active_sel=pending, timeout_flag=1, fade-in on the new source.
- run dropped mid-fade -> IDLE next cycle, dout_valid=0. On run=1 again -> PLAY immediately at g=G_FULL on the current select.
